// File: rtl/goe_lut_pkg.sv
// Shared constants, FSM encoding and addressing helper for the GOE lookup-table loader.
package goe_lut_pkg;

    localparam int N_ENTRY          = 256;
    localparam int ENTRY_W          = 2;
    localparam int WORD_W           = 32;
    localparam int ENTRIES_PER_WORD = WORD_W / ENTRY_W;
    localparam int N_WORD           = N_ENTRY / ENTRIES_PER_WORD;
    localparam int TABLE_W          = N_ENTRY * ENTRY_W;
    localparam int ADDR_W           = $clog2(N_WORD);
    localparam int CNT_W            = ADDR_W + 1;
    localparam int LSB_W            = $clog2(TABLE_W);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_WORD);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_FULL   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // Bit offset of a 32-bit word inside the flat table (word index * WORD_W).
    function automatic logic [LSB_W-1:0] word_lsb(input logic [ADDR_W-1:0] idx);
        return {idx, {$clog2(WORD_W){1'b0}}};
    endfunction

endpackage

// File: rtl/goe_lut_shadow.sv
// Shadow register file: word-addressed writes, whole table visible as one flat vector.
module goe_lut_shadow
    import goe_lut_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [WORD_W-1:0]  wdata,
    output logic [TABLE_W-1:0] table_flat
);

    logic [TABLE_W-1:0] mem_q;
    logic [TABLE_W-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[word_lsb(waddr) +: WORD_W] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign table_flat = mem_q;

endmodule

// File: rtl/goe_lut_writer.sv
// GOE lookup-table loader: streams words into a shadow table and publishes it
// atomically to the active table on commit, with registered readback.
module goe_lut_writer
    import goe_lut_pkg::*;
(
    input  logic               s00_axi_aclk,
    input  logic               s00_axi_aresetn,
    input  logic               load_start,
    input  logic [WORD_W-1:0]  wr_data,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic               commit,
    input  logic               abort,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [WORD_W-1:0]  rd_data,
    output logic [TABLE_W-1:0] table_active,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic [TABLE_W-1:0] table_q, table_d;
    logic [WORD_W-1:0]  rd_data_q, rd_data_d;
    logic [TABLE_W-1:0] shadow_flat;
    logic               wr_ready_c;
    logic               accept;

    goe_lut_shadow u_shadow (
        .clk        (s00_axi_aclk),
        .rst_n      (s00_axi_aresetn),
        .we         (accept),
        .waddr      (cnt_q[ADDR_W-1:0]),
        .wdata      (wr_data),
        .table_flat (shadow_flat)
    );

    // Priority abort > load_start > commit; the COMMIT cycle always completes its copy.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        done_d     = 1'b0;
        table_d    = table_q;
        rd_data_d  = table_q[word_lsb(rd_addr) +: WORD_W];
        wr_ready_c = (state_q == ST_LOAD) && (cnt_q < CNT_FULL) && !load_start;
        accept     = wr_valid && wr_ready_c;

        if (state_q == ST_COMMIT) begin
            table_d = shadow_flat;
            done_d  = 1'b1;
            state_d = ST_IDLE;
            if (load_start && !abort) begin
                state_d = ST_LOAD;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
        end else if (abort) begin
            state_d = ST_IDLE;
        end else if (load_start) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (commit) begin
                        err_d = 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (commit && (cnt_q < CNT_FULL)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (commit) begin
                        state_d = ST_COMMIT;
                    end else if (cnt_q == CNT_FULL) begin
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (wr_valid) begin
                        err_d = 1'b1;
                    end
                    if (commit) begin
                        state_d = ST_COMMIT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            table_q   <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            done_q    <= done_d;
            table_q   <= table_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign wr_ready     = wr_ready_c;
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign err          = err_q;
    assign table_active = table_q;
    assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_goe_lut_writer.sv
// Randomized scenario bench for goe_lut_writer against a word-array model of the tables.
module tb_goe_lut_writer;

    logic         clk;
    logic         rst_n;
    logic         load_start;
    logic [31:0]  wr_data;
    logic         wr_valid;
    logic         wr_ready;
    logic         commit;
    logic         abort;
    logic [3:0]   rd_addr;
    logic [31:0]  rd_data;
    logic [511:0] table_active;
    logic         busy;
    logic         done;
    logic         err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_shadow [16];
    logic [31:0] m_active [16];

    goe_lut_writer dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .load_start      (load_start),
        .wr_data         (wr_data),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .commit          (commit),
        .abort           (abort),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .table_active    (table_active),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (got running, want finished)");
        $fatal(1, "watchdog");
    end

    function automatic logic [511:0] model_flat();
        logic [511:0] f;
        for (int i = 0; i < 16; i++) f[i*32 +: 32] = m_active[i];
        return f;
    endfunction

    function automatic logic [1:0] model_entry(input int idx);
        logic [31:0] w;
        w = m_active[idx / 16];
        return w[2*(idx % 16) +: 2];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d);
        int n;
        n = 0;
        wr_data  = d;
        wr_valid = 1'b1;
        #1;
        while (!wr_ready && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_word_timeout: wr_ready=%b want 1", wr_ready);
        end else begin
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic load_full(input logic use_pattern);
        logic [31:0] d;
        pulse_load_start();
        for (int i = 0; i < 16; i++) begin
            d = use_pattern ? 32'h1111_1111 * (i % 4) : $urandom;
            send_word(d);
            m_shadow[i] = d;
        end
    endtask

    // FSM passes through FULL, then COMMIT, then the copy edge.
    task automatic do_commit_and_check(input string tag);
        int done_cnt;
        tick();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        done_cnt = (done === 1'b1) ? 1 : 0;
        tick();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done: done=%b want 1", tag, done);
        end
        if (done === 1'b1) done_cnt++;
        for (int i = 0; i < 16; i++) m_active[i] = m_shadow[i];
        checks++;
        if (table_active !== model_flat()) begin
            failures++;
            $display("FAIL %s_table: table_active=%h want %h", tag, table_active, model_flat());
        end
        tick();
        if (done === 1'b1) done_cnt++;
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_once: done_pulses=%0d busy=%b want 1 and 0", tag, done_cnt, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load_start = 0; wr_data = 0; wr_valid = 0; commit = 0; abort = 0; rd_addr = 0;
        for (int i = 0; i < 16; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (table_active !== 512'd0 || rd_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_tables: table_active=%h rd_data=%h want 0", table_active, rd_data);
        end
        checks++;
        if ({wr_ready, busy, err, done} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: ready/busy/err/done=%b want 0000", {wr_ready, busy, err, done});
        end
    endtask

    task automatic test_idle_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_commit: err=%b busy=%b done=%b want 1 0 0", err, busy, done);
        end
        tick();
        checks++;
        if (done !== 1'b0 || table_active !== model_flat()) begin
            failures++;
            $display("FAIL idle_commit_nocopy: done=%b table=%h want 0 and %h", done, table_active, model_flat());
        end
    endtask

    task automatic test_full_load();
        logic [3:0] a;
        load_full(1'b1);
        do_commit_and_check("full_load");
        checks++;
        if (table_active[33:32] !== model_entry(16) || table_active[65:64] !== model_entry(32)) begin
            failures++;
            $display("FAIL full_load_entries: e16=%b e32=%b want %b %b",
                     table_active[33:32], table_active[65:64], model_entry(16), model_entry(32));
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL full_load_err: err=%b want 0", err);
        end
        rd_addr = 4'd3;
        tick();
        checks++;
        if (rd_data !== 32'h3333_3333) begin
            failures++;
            $display("FAIL readback_3: rd_data=%h want 33333333", rd_data);
        end
        for (int k = 0; k < 6; k++) begin
            a = 4'($urandom_range(0, 15));
            rd_addr = a;
            tick();
            checks++;
            if (rd_data !== m_active[a]) begin
                failures++;
                $display("FAIL readback_rand: addr=%0d rd_data=%h want %h", a, rd_data, m_active[a]);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] stream [20];
        int accepted;
        wr_valid   = 1'b1;
        wr_data    = $urandom;
        load_start = 1'b1;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready_on_start: wr_ready=%b want 0", wr_ready);
        end
        tick();
        load_start = 1'b0;
        accepted = 0;
        for (int c = 0; c < 20; c++) begin
            stream[c] = $urandom;
            wr_data = stream[c];
            #1;
            if (wr_ready === 1'b1) accepted++;
            tick();
        end
        wr_valid = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) m_shadow[i] = stream[i];
        checks++;
        if (accepted != 16 || wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_beats: accepted=%0d wr_ready=%b want 16 and 0", accepted, wr_ready);
        end
        checks++;
        if (err !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL bp_overrun: err=%b busy=%b want 1 1", err, busy);
        end
        checks++;
        if (table_active !== model_flat()) begin
            failures++;
            $display("FAIL bp_table_held: table=%h want %h", table_active, model_flat());
        end
        do_commit_and_check("bp_commit");
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL bp_err_sticky: err=%b want 1", err);
        end
    endtask

    task automatic test_short_load();
        logic [31:0] d;
        int done_cnt;
        pulse_load_start();
        for (int i = 0; i < 10; i++) begin
            d = $urandom;
            send_word(d);
            m_shadow[i] = d;
        end
        commit = 1'b1;
        tick();
        commit = 1'b0;
        done_cnt = (done === 1'b1) ? 1 : 0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL short_load_state: err=%b busy=%b want 1 0", err, busy);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt != 0 || table_active !== model_flat()) begin
            failures++;
            $display("FAIL short_load_nocopy: done_pulses=%0d table=%h want 0 and %h",
                     done_cnt, table_active, model_flat());
        end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        pulse_load_start();
        for (int i = 0; i < 5; i++) begin
            d = $urandom;
            send_word(d);
            m_shadow[i] = d;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || err !== 1'b0 || table_active !== model_flat()) begin
            failures++;
            $display("FAIL abort_state: busy=%b err=%b table=%h want 0 0 %h",
                     busy, err, table_active, model_flat());
        end
        load_full(1'b0);
        do_commit_and_check("after_abort");
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL after_abort_err: err=%b want 0", err);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        rd_addr = 4'($urandom_range(0, 15));
        pulse_load_start();
        for (int i = 0; i < 7; i++) begin
            d = $urandom;
            send_word(d);
            m_shadow[i] = d;
        end
        wr_data  = $urandom;
        wr_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
        checks++;
        if (table_active !== model_flat() || rd_data !== 32'd0) begin
            failures++;
            $display("FAIL async_reset_tables: table=%h rd_data=%h want 0", table_active, rd_data);
        end
        checks++;
        if ({wr_ready, busy, err, done} !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset_flags: ready/busy/err/done=%b want 0000", {wr_ready, busy, err, done});
        end
        wr_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || wr_ready !== 1'b0 || table_active !== 512'd0) begin
            failures++;
            $display("FAIL async_reset_release: busy=%b wr_ready=%b want 0 0", busy, wr_ready);
        end
    endtask

    initial begin
        test_reset();
        test_idle_commit();
        test_full_load();
        test_back_pressure();
        test_short_load();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
